gate_truth_checker: RTL

//  Self-checking hardware counterpart to the gate-level testbenches. It drives the
//  x/y inputs of a 2-input logic-gate DUT through the full truth table, waits a settle

---
 rtl/gate_truth_checker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gate_truth_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gate_truth_checker                                                         |
// | Sweeps a 2-input gate through its truth table and counts response errors.  |
// | Optional GATE_CHK_ERR_LOG_EN: first-mismatch vector capture outputs.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gate_truth_checker #(
  parameter int SETTLE_CYC = 4,
  parameter int PASSES     = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  output logic             dut_x,
  output logic             dut_y,
  input  logic             dut_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       vec_idx
`ifdef GATE_CHK_ERR_LOG_EN
  ,
  output logic             first_err_valid,
  output logic [1:0]       first_err_vec
`endif
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_settle = 2'd1;
  localparam logic [1:0] c_st_sample = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;

  localparam int c_tmr_w  = $clog2(SETTLE_CYC + 1);
  localparam int c_pass_w = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [c_tmr_w-1:0]  c_tmr_last  = c_tmr_w'(SETTLE_CYC);
  localparam logic [c_tmr_w-1:0]  c_tmr_one   = c_tmr_w'(1);
  localparam logic [c_pass_w-1:0] c_pass_last = c_pass_w'(PASSES - 1);
  localparam logic [c_pass_w-1:0] c_pass_one  = c_pass_w'(1);
  localparam logic [CNT_W-1:0]    c_err_max   = '1;
  localparam logic [CNT_W-1:0]    c_err_one   = CNT_W'(1);
  localparam logic [2:0]          c_op_inval  = 3'd7;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [c_tmr_w-1:0]  r_timer;
  logic [c_pass_w-1:0] r_pass_cnt;
  logic [2:0]          r_op;
  logic [1:0]          r_vec;
  logic [CNT_W-1:0]    r_err;
  logic                r_pass;
  logic                w_expect;
  logic                w_mismatch;
  logic                w_last_vec;
  logic [CNT_W-1:0]    w_err_nxt;

  always_comb begin
    w_expect = 1'b0;
    case (r_op)
      3'd0:    w_expect =   r_vec[1] & r_vec[0];
      3'd1:    w_expect =   r_vec[1] | r_vec[0];
      3'd2:    w_expect =  ~r_vec[1];
      3'd3:    w_expect = ~(r_vec[1] & r_vec[0]);
      3'd4:    w_expect = ~(r_vec[1] | r_vec[0]);
      3'd5:    w_expect =   r_vec[1] ^ r_vec[0];
      3'd6:    w_expect = ~(r_vec[1] ^ r_vec[0]);
      default: w_expect = 1'b0;
    endcase
  end

  assign w_mismatch = (r_state == c_st_sample) && (dut_f != w_expect);
  assign w_last_vec = (r_vec == 2'd3) && (r_pass_cnt == c_pass_last);
  assign w_err_nxt  = (w_mismatch && (r_err != c_err_max)) ? (r_err + c_err_one) : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (start) w_state_nxt = (op == c_op_inval) ? c_st_done : c_st_settle;
      c_st_settle: if (r_timer == c_tmr_last) w_state_nxt = c_st_sample;
      c_st_sample: w_state_nxt = w_last_vec ? c_st_done : c_st_settle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state != c_st_idle);
    done = (r_state == c_st_done);
  end

  // The first vector settles from 0 (one extra cycle after the sweep restarts
  // from an arbitrary previous vector); later vectors reload the timer at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer    <= '0;
      r_pass_cnt <= '0;
      r_op       <= '0;
      r_vec      <= '0;
      r_err      <= '0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_op       <= op;
            r_err      <= '0;
            r_pass     <= 1'b0;
            r_vec      <= '0;
            r_timer    <= '0;
            r_pass_cnt <= '0;
          end
        end
        c_st_settle: begin
          if (r_timer != c_tmr_last) r_timer <= r_timer + c_tmr_one;
        end
        c_st_sample: begin
          r_err <= w_err_nxt;
          if (w_last_vec) begin
            r_pass <= (w_err_nxt == '0);
          end else begin
            r_vec   <= r_vec + 2'd1;
            r_timer <= c_tmr_one;
            if (r_vec == 2'd3) r_pass_cnt <= r_pass_cnt + c_pass_one;
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_x   = r_vec[1];
  assign dut_y   = r_vec[0];
  assign vec_idx = r_vec;
  assign err_cnt = r_err;
  assign pass    = r_pass;

`ifdef GATE_CHK_ERR_LOG_EN
  logic       r_first_valid;
  logic [1:0] r_first_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_valid <= 1'b0;
      r_first_vec   <= '0;
    end else if ((r_state == c_st_idle) && start) begin
      r_first_valid <= 1'b0;
      r_first_vec   <= '0;
    end else if (w_mismatch && !r_first_valid) begin
      r_first_valid <= 1'b1;
      r_first_vec   <= r_vec;
    end
  end

  assign first_err_valid = r_first_valid;
  assign first_err_vec   = r_first_vec;
`else
  // No first-mismatch capture in this build.
`endif

endmodule
`default_nettype wire
